uart_frame_arbiter: RTL and testbench
=====================================

# uart_frame_arbiter

Shares the single `uart_tx` instance between `NUM_REQ` byte producers, for example the event counter and future fault-injection monitors. Each granted request becomes a 4-byte frame: sync, source ID, data, checksum. The block sits between the producers and `uart_tx` in `top`. It drives `uart_tx`'s DV/byte inputs and paces itself from `uart_tx`'s Active/Done outputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.
- `ID_W`, derived: $clog2(NUM_REQ).

Ports:
- `i_Clk`, in, 1: system clock, CLK_50.
- `i_Rst_n`, in, 1: asynchronous, active-low reset.
- `i_Req_DV`, in, NUM_REQ: per-requester data valid. Held high until acknowledged.
- `i_Req_Data`, in, 8*NUM_REQ: requester k's byte at [8k+7:8k]. Stable while its DV is high.
- `o_Req_Ack`, out, NUM_REQ: one-cycle pulse; the granted requester's byte has been captured.
- `o_Tx_DV`, out, 1: one-cycle start pulse to `uart_tx`.
- `o_Tx_Byte`, out, 8: byte for `uart_tx`. Held from the DV pulse until the next DV pulse.
- `i_Tx_Active`, in, 1: from `uart_tx`.
- `i_Tx_Done`, in, 1: from `uart_tx`; one-cycle end-of-stop-bit pulse.
- `o_Busy`, out, 1: high from grant until the last byte's Done.
- `o_Grant_Id`, out, ID_W: ID of the frame currently in progress.

## Operation
- States: IDLE, SEND, WAIT_DONE.
- **IDLE:**
  - If any `i_Req_DV` is high, grant round-robin. The search starts at `last_grant+1` mod NUM_REQ.
  - Capture the granted data into `r_Data` and the ID into `o_Grant_Id`.
  - Compute `r_Chk = SYNC_BYTE ^ {pad, ID} ^ data`.
  - Pulse `o_Req_Ack[ID]`, set `o_Busy`, set byte index to 0, go to SEND.
- **SEND:**
  - When `i_Tx_Active` is low, pulse `o_Tx_DV` with `o_Tx_Byte = frame[idx]`, then go to WAIT_DONE.
  - Frame bytes: idx 0 = SYNC_BYTE; idx 1 = ID zero-extended to 8 bits; idx 2 = data; idx 3 = checksum.
  - While `i_Tx_Active` is high, stay in SEND and emit no pulse.
- **WAIT_DONE:**
  - On `i_Tx_Done`: if idx == 3, update `last_grant` to ID, clear `o_Busy`, go to IDLE.
  - Otherwise increment idx and go to SEND.
  - `i_Tx_Active` is ignored in this state.
- Requests raised during a frame are queued only by the requester holding its DV. They are considered on the next entry to IDLE.
- Several simultaneous requests: exactly one is granted per frame, in round-robin order. No requester is starved.
- A DV that drops before being granted is lost silently. This is the requester's responsibility.
- An `i_Tx_Done` seen in IDLE or SEND is ignored.
- Reset values:
  - state IDLE, idx 0.
  - `o_Req_Ack` 0, `o_Tx_DV` 0, `o_Tx_Byte` 8'h00, `o_Busy` 0, `o_Grant_Id` 0.
  - `last_grant` = NUM_REQ-1, so requester 0 has priority first.
- Reset mid-frame aborts the frame immediately. A byte already inside `uart_tx` still completes on the line. The host resynchronises on SYNC_BYTE plus the checksum.

## Timing
- The DV in the request cycle is sampled at edge N. `o_Req_Ack` and `o_Busy` are high in the cycle after edge N, and the state is SEND.
- First `o_Tx_DV` occurs at edge N+1, given `i_Tx_Active` low, i.e. 2 cycles after the request.
- Per byte: `i_Tx_Done` at edge M leads to the next `o_Tx_DV` at edge M+2, through WAIT_DONE→SEND→pulse.
- Frame duration is about 4×10×CLKS_PER_BIT + 8 cycles.
- Earliest next grant: 1 cycle after the final Done returns the FSM to IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `uart_frame_pkg` contains:
  - the state enum (IDLE/SEND/WAIT_DONE);
  - `FRAME_LEN = 4`;
  - the default `SYNC_BYTE`;
  - the byte-index width.
- Sub-module `rr_arbiter`, parameterised on NUM_REQ. Inputs: request vector and `last_grant`. Outputs: grant one-hot, grant ID, and `any`. It is combinational. `last_grant` is registered in the parent.
- The parent holds the FSM, the capture registers, the checksum and the frame mux.

## Test plan
- Single request: `i_Req_DV[2]=1`, data 8'h3C, with `uart_tx` model (CLKS_PER_BIT=4).
  - Line carries A5, 02, 3C, 9B.
  - `o_Req_Ack[2]` pulses once, 1 cycle after sampling.
  - `o_Busy` falls 1 cycle after the 4th Done.
- All four requesters held high from reset, data = 8'h10+k.
  - Frames are emitted in ID order 0, 1, 2, 3, 0.
  - Checksums are A5^k^(10+k).
- `i_Tx_Active` forced high when SEND is entered: no `o_Tx_DV` pulse until Active drops. The DV pulse then appears on the next edge.
- Request 1 arrives while the frame for 0 is at idx 2: frame 0 completes unchanged, and requester 1 is granted 1 cycle after frame 0's final Done.
- `i_Rst_n` asserted during WAIT_DONE of idx 1:
  - All outputs return to their reset values asynchronously.
  - After release, a pending request starts a fresh frame with SYNC_BYTE.
  - Priority restarts at 0.
- Spurious `i_Tx_Done` pulsed in IDLE and in SEND: no state change and no byte skipped.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame arbiter.
//   state_e        : frame FSM states
//   FRAME_LEN      : bytes per frame (sync, id, data, checksum)
//   DEF_SYNC_BYTE  : default frame sync byte
//   IDX_W          : width of the byte-in-frame index
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  localparam int unsigned FRAME_LEN     = 4;
  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
  localparam int unsigned IDX_W         = $clog2(FRAME_LEN);

endpackage

// File: rtl/uart_frame_arbiter_rr.sv
// Combinational round-robin arbiter.
//   i_Req        : request vector
//   i_Last_Grant : ID granted last; search starts one above it (mod NUM_REQ)
//   o_Gnt        : one-hot grant
//   o_Gnt_Id     : binary grant ID
//   o_Any        : at least one request present
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [ID_W-1:0]    i_Last_Grant,
  output logic [NUM_REQ-1:0] o_Gnt,
  output logic [ID_W-1:0]    o_Gnt_Id,
  output logic               o_Any
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    o_Gnt    = '0;
    o_Gnt_Id = '0;
    found    = 1'b0;
    cand     = '0;
    // Walk NUM_REQ candidates starting after the last grant; the
    // last grant itself is examined last, so nobody can be starved.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((32'(i_Last_Grant) + off) % NUM_REQ);
      if (!found && i_Req[cand]) begin
        found    = 1'b1;
        o_Gnt_Id = cand;
      end
    end
    if (found) o_Gnt[o_Gnt_Id] = 1'b1;
    o_Any = found;
  end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers. Each granted request
// is sent as a 4-byte frame: SYNC_BYTE, source ID, data, checksum
// (SYNC_BYTE ^ ID ^ data). All outputs are registered.
//   i_Clk, i_Rst_n   : clock, async active-low reset
//   i_Req_DV/_Data   : per-requester valid and byte (byte k at [8k+7:8k])
//   o_Req_Ack        : one-cycle pulse when the granted byte is captured
//   o_Tx_DV/_Byte    : start pulse and byte for uart_tx
//   i_Tx_Active/Done : uart_tx status
//   o_Busy           : frame in progress
//   o_Grant_Id       : ID of the frame in progress
module uart_frame_arbiter
  import uart_frame_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Data,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic [ID_W-1:0]      o_Grant_Id
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           data_q, data_d;
  logic [7:0]           chk_q, chk_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_id;
  logic                 arb_any;
  logic [7:0]           arb_data;
  logic [7:0]           frame_byte;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_Req        (i_Req_DV),
    .i_Last_Grant (last_grant_q),
    .o_Gnt        (arb_gnt),
    .o_Gnt_Id     (arb_id),
    .o_Any        (arb_any)
  );

  assign arb_data = i_Req_Data[8*arb_id +: 8];

  always_comb begin
    case (idx_q)
      IDX_W'(0): frame_byte = SYNC_BYTE;
      IDX_W'(1): frame_byte = 8'(grant_id_q);
      IDX_W'(2): frame_byte = data_q;
      default:   frame_byte = chk_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    chk_d        = chk_q;
    ack_d        = '0;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    busy_d       = busy_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          data_d     = arb_data;
          chk_d      = SYNC_BYTE ^ 8'(arb_id) ^ arb_data;
          grant_id_d = arb_id;
          ack_d      = arb_gnt;
          busy_d     = 1'b1;
          idx_d      = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!i_Tx_Active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = frame_byte;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          if (idx_q == LAST_IDX) begin
            last_grant_d = grant_id_q;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      chk_q        <= '0;
      ack_q        <= '0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= '0;
      busy_q       <= 1'b0;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      chk_q        <= chk_d;
      ack_q        <= ack_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_Req_Ack  = ack_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Busy     = busy_q;
  assign o_Grant_Id = grant_id_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter with a simple uart_tx model
// (CLKS_PER_BIT = 4, 10 bits per byte).
module tb_uart_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_dv = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [1:0]  gid;
  logic        tx_active, tx_done;

  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [5:0]  m_cnt = '0;
  logic        force_active = 1'b0, spur_done = 1'b0;

  logic [7:0]  sent[$];
  int          grants[$];
  int          ack_cnt[4];
  int          done_cnt = 0;
  int          n_cmp = 0, n_err = 0;

  assign tx_active = m_busy | force_active;
  assign tx_done   = m_done | spur_done;

  uart_frame_arbiter #(.NUM_REQ(4), .SYNC_BYTE(8'hA5)) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Req_DV    (req_dv),
    .i_Req_Data  (req_data),
    .o_Req_Ack   (ack),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Busy      (busy),
    .o_Grant_Id  (gid)
  );

  always #5 clk = ~clk;

  // uart_tx model: 40 clocks per byte, Done pulses as Active falls.
  // Not reset by the arbiter reset: an in-flight byte always completes.
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_busy) begin
      if (m_cnt == 6'd39) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 6'd1;
      end
    end else if (tx_dv) begin
      m_busy <= 1'b1;
      m_cnt  <= '0;
      sent.push_back(tx_byte);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
        if (ack[k]) begin
          ack_cnt[k]++;
          grants.push_back(k);
        end
      if (tx_done) done_cnt++;
    end
  endtask

  task automatic wait_dones(input int n, input string tag);
    int b = 0;
    while (done_cnt < n && b < 1000) begin
      tick();
      b++;
    end
    check_val(tag, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic wait_sent(input int n, input string tag);
    int b = 0;
    while (sent.size() < n && b < 1000) begin
      tick();
      b++;
    end
    check_val(tag, 32'(sent.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while (busy && b < 1000) begin
      tick();
      b++;
    end
    check_val(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] w);
    wait_sent(4, {tag, "_wait"});
    for (int i = 0; i < 4; i++) begin
      logic [7:0] got;
      got = (sent.size() > 0) ? sent.pop_front() : 8'hxx;
      check_val($sformatf("%s_b%0d", tag, i), {24'd0, got}, {24'd0, w[31-8*i -: 8]});
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_ack"},   {28'd0, ack},     32'd0);
    check_val({tag, "_txdv"},  {31'd0, tx_dv},   32'd0);
    check_val({tag, "_txbyte"},{24'd0, tx_byte}, 32'd0);
    check_val({tag, "_busy"},  {31'd0, busy},    32'd0);
    check_val({tag, "_gid"},   {30'd0, gid},     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit dropped;
    logic [31:0] exp_frames[5];
    int exp_order[5];
    exp_frames = '{32'hA50010B5, 32'hA50111B5, 32'hA50212B5, 32'hA50313B5, 32'hA50010B5};
    exp_order  = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 4; k++) ack_cnt[k] = 0;

    // Reset values
    tick(3);
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single request from 2, data 3C
    done_cnt = 0;
    req_data[23:16] = 8'h3C;
    req_dv[2] = 1'b1;
    tick();
    check_val("t1_ack", {28'd0, ack}, 32'h4);
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    check_val("t1_gid", {30'd0, gid}, 32'd2);
    req_dv[2] = 1'b0;
    tick();
    check_val("t1_ack_pulse", {28'd0, ack}, 32'd0);
    check_val("t1_txdv", {31'd0, tx_dv}, 32'd1);
    check_val("t1_byte0", {24'd0, tx_byte}, 32'hA5);
    wait_dones(4, "t1_dones");
    check_val("t1_busy_at_done4", {31'd0, busy}, 32'd1);
    tick();
    check_val("t1_busy_after_done4", {31'd0, busy}, 32'd0);
    check_frame("t1", 32'hA5023C9B);
    check_val("t1_ack_count", 32'(ack_cnt[2]), 32'd1);

    // All four requesters held from reset
    rst_n = 1'b0;
    req_data = 32'h13121110;
    req_dv = 4'hF;
    tick(2);
    grants.delete();
    sent.delete();
    rst_n = 1'b1;
    dropped = 1'b0;
    for (int b = 0; b < 3000; b++) begin
      tick();
      if (!dropped && grants.size() >= 5) begin
        req_dv = '0;
        dropped = 1'b1;
      end
      if (dropped && !busy) break;
    end
    check_val("t2_ngrants", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("t2_order%0d", i), (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF, 32'(exp_order[i]));
      check_frame($sformatf("t2_f%0d", i), exp_frames[i]);
    end

    // Active held high as SEND is entered
    force_active = 1'b1;
    req_data[15:8] = 8'h77;
    req_dv[1] = 1'b1;
    tick();
    check_val("t3_ack", {28'd0, ack}, 32'h2);
    req_dv[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("t3_hold%0d", i), {31'd0, tx_dv}, 32'd0);
    end
    force_active = 1'b0;
    tick();
    check_val("t3_txdv", {31'd0, tx_dv}, 32'd1);
    check_val("t3_byte0", {24'd0, tx_byte}, 32'hA5);
    wait_idle("t3_idle");
    check_frame("t3", 32'hA50177D3);

    // Request 1 arrives while frame 0 is at idx 2
    done_cnt = 0;
    req_data[7:0] = 8'h5A;
    req_dv[0] = 1'b1;
    tick();
    check_val("t4_ack0", {28'd0, ack}, 32'h1);
    req_dv[0] = 1'b0;
    wait_sent(3, "t4_idx2");
    req_data[15:8] = 8'hC3;
    req_dv[1] = 1'b1;
    wait_dones(4, "t4_dones");
    tick();
    check_val("t4_busy_low", {31'd0, busy}, 32'd0);
    check_val("t4_no_early_ack", {28'd0, ack}, 32'd0);
    tick();
    check_val("t4_ack1", {28'd0, ack}, 32'h2);
    check_val("t4_gid1", {30'd0, gid}, 32'd1);
    req_dv[1] = 1'b0;
    check_frame("t4_f0", 32'hA5005AFF);
    wait_idle("t4_idle");
    check_frame("t4_f1", 32'hA501C367);

    // Reset during WAIT_DONE of idx 1
    req_data[31:24] = 8'h44;
    req_dv[3] = 1'b1;
    tick();
    check_val("t5_ack3", {28'd0, ack}, 32'h8);
    req_dv[3] = 1'b0;
    wait_sent(2, "t5_idx1");
    req_data[7:0] = 8'h81;
    req_dv = 4'b1001;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("t5_async");
    tick(2);
    rst_n = 1'b1;
    sent.delete();
    tick();
    check_val("t5_ack_prio0", {28'd0, ack}, 32'h1);
    check_val("t5_gid", {30'd0, gid}, 32'd0);
    req_dv = '0;
    wait_idle("t5_idle");
    check_frame("t5", 32'hA5008124);

    // Spurious Done in IDLE and in SEND
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    check_val("t6_idle_busy", {31'd0, busy}, 32'd0);
    check_val("t6_idle_txdv", {31'd0, tx_dv}, 32'd0);
    tick();
    check_val("t6_idle_busy2", {31'd0, busy}, 32'd0);
    force_active = 1'b1;
    req_data[23:16] = 8'h96;
    req_dv[2] = 1'b1;
    tick();
    check_val("t6_ack", {28'd0, ack}, 32'h4);
    req_dv[2] = 1'b0;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    check_val("t6_send_txdv", {31'd0, tx_dv}, 32'd0);
    force_active = 1'b0;
    tick();
    check_val("t6_txdv", {31'd0, tx_dv}, 32'd1);
    check_val("t6_byte0", {24'd0, tx_byte}, 32'hA5);
    wait_idle("t6_idle");
    check_frame("t6", 32'hA5029631);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
